// File: rtl/dac_serial_pkg.sv
// Shared frame constants and FSM encoding for the DAC serial writer.
package dac_serial_pkg;

  typedef logic [1:0] state_t;

  localparam int           FRAME_W    = 32;
  localparam logic [3:0]   CMD_WR_UPD = 4'h3;
  localparam logic [31:0]  REF_FRAME  = 32'h0800_0001;

  localparam state_t ST_INIT  = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  function automatic logic [31:0] wr_frame(input logic [3:0] chan, input logic [15:0] data);
    return {4'h0, CMD_WR_UPD, chan, data, 4'h0};
  endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// SCLK half-period divider: ticks every CLK_DIV cycles while enabled and
// tracks which SCLK half (high/low) is in progress.
module dac_sclk_div
  import dac_serial_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_phase_hi
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase_hi;

  assign o_tick     = i_en && (r_cnt == LAST);
  assign o_phase_hi = r_phase_hi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_phase_hi <= 1'b1;
    end else if (!i_en) begin
      r_cnt      <= '0;
      r_phase_hi <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt      <= '0;
      r_phase_hi <= ~r_phase_hi;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_serial_writer.sv
// Reader end of the DAC instruction queue: pops {chan, data} words and
// serialises each as a 32-bit frame (MSB first, DAC samples on SCLK fall).
module dac_serial_writer
  import dac_serial_pkg::*;
#(
  parameter int W_DATA   = 16,
  parameter int W_CHS    = 3,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_GAP = 4,
  parameter int INIT_EN  = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [W_CHS-1:0]  chan_in,
  input  logic              data_valid_in,
  output logic              rd_ack_out,
  output logic              dac_sclk_out,
  output logic              dac_sync_n_out,
  output logic              dac_din_out,
  output logic              busy_out
);

  localparam int GW = $clog2(SYNC_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

  state_t             r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [4:0]         r_bitcnt;
  logic [GW-1:0]      r_gapcnt;
  logic               r_ack;
  logic               r_sclk;
  logic               r_sync_n;
  logic               r_busy;

  logic               w_shift_en;
  logic               w_tick;
  logic               w_phase_hi;
  logic               w_load;
  logic [3:0]         w_chan4;
  logic [FRAME_W-1:0] w_load_frame;

  always_comb begin
    w_chan4 = '0;
    w_chan4[W_CHS-1:0] = chan_in;
  end

  assign w_load       = (r_state == ST_INIT) || ((r_state == ST_IDLE) && data_valid_in);
  assign w_load_frame = (r_state == ST_INIT) ? REF_FRAME : wr_frame(w_chan4, data_in);
  assign w_shift_en   = (r_state == ST_SHIFT);

  dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .i_clk      (clk_in),
    .i_rst_n    (reset_in),
    .i_en       (w_shift_en),
    .o_tick     (w_tick),
    .o_phase_hi (w_phase_hi)
  );

  // din is the shift register MSB, so clearing the register at frame end idles din low.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state  <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_ack    <= 1'b0;
      r_sclk   <= 1'b1;
      r_sync_n <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_ack <= w_load && (r_state == ST_IDLE);
      if (w_load) begin
        r_shreg  <= w_load_frame;
        r_bitcnt <= 5'd31;
        r_sclk   <= 1'b1;
        r_sync_n <= 1'b0;
        r_busy   <= 1'b1;
        r_state  <= ST_SHIFT;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_tick) begin
              if (w_phase_hi) begin
                r_sclk <= 1'b0;
              end else if (r_bitcnt == 5'd0) begin
                r_shreg  <= '0;
                r_sclk   <= 1'b1;
                r_sync_n <= 1'b1;
                r_gapcnt <= '0;
                r_state  <= ST_GAP;
              end else begin
                r_shreg  <= {r_shreg[FRAME_W-2:0], 1'b0};
                r_sclk   <= 1'b1;
                r_bitcnt <= r_bitcnt - 5'd1;
              end
            end
          end
          ST_GAP: begin
            if (r_gapcnt == GAP_LAST) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_gapcnt <= r_gapcnt + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_ack_out     = r_ack;
  assign dac_sclk_out   = r_sclk;
  assign dac_sync_n_out = r_sync_n;
  assign dac_din_out    = r_shreg[FRAME_W-1];
  assign busy_out       = r_busy;

endmodule
